// File: rtl/tug_pkg.sv
// tug_pkg: shared defaults, position type and CPU-opponent LFSR constants for the tug-of-war playfield.
package tug_pkg;
  localparam int NUM_LEDS_DEF = 9;
  localparam int CENTER_DEF = 5;
  localparam int POS_W = $clog2(NUM_LEDS_DEF + 1);
  typedef logic [POS_W-1:0] pos_t;
  localparam int LFSR_W = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;
endpackage

// File: rtl/key_pulse.sv
// key_pulse: synchronises a raw key, detects its rising edge and emits a registered one-cycle pulse.
module key_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic clr_i,
  output logic pulse_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q, pulse_q;
  // All-ones reset makes a key held through reset look already-seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~hist_q & ~clr_i;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/tug_field.sv
// tug_field: key conditioning and one-hot light movement feeding the win detector; TUG_CPU_OPPONENT_EN swaps KeyR for an LFSR opponent.
module tug_field
  import tug_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int CENTER = CENTER_DEF,
  parameter int SYNC_STAGES = 2,
  parameter logic [9:0] CPU_THRESH = 10'd3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                KeyL,
  input  logic                KeyR,
  input  logic                gameReset,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                P1LED9,
  output logic                P2LED1,
  output logic                L,
  output logic                R
);
  localparam int PW = $clog2(NUM_LEDS + 1);
  logic [PW-1:0] pos_q, pos_d;
  logic at_max, at_min;
  key_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_key_l (
    .clk(Clock), .rst(Reset), .key_i(KeyL), .clr_i(gameReset), .pulse_o(L)
  );
`ifdef TUG_CPU_OPPONENT_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic cpu_r_q;
  logic unused_keyr;
  assign unused_keyr = KeyR;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr_q  <= LFSR_SEED;
      cpu_r_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      cpu_r_q <= (lfsr_q <= CPU_THRESH) & ~gameReset;
    end
  end
  assign R = cpu_r_q;
`else
  logic [9:0] unused_thresh;
  assign unused_thresh = CPU_THRESH;
  key_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_key_r (
    .clk(Clock), .rst(Reset), .key_i(KeyR), .clr_i(gameReset), .pulse_o(R)
  );
`endif
  assign at_max = pos_q == PW'(NUM_LEDS);
  assign at_min = pos_q == PW'(1);
  always_comb begin
    pos_d = gameReset ? PW'(CENTER) :
            (L & ~R & ~at_max) ? pos_q + PW'(1) :
            (R & ~L & ~at_min) ? pos_q - PW'(1) : pos_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) pos_q <= PW'(CENTER);
    else pos_q <= pos_d;
  end
  assign LEDR = {{(NUM_LEDS-1){1'b0}}, 1'b1} << (pos_q - PW'(1));
  assign P1LED9 = at_max;
  assign P2LED1 = at_min;
endmodule

// File: tb/tb_tug_field.sv
// tb_tug_field: directed checks of reset, key pulsing, saturation, simultaneous presses and gameReset.
module tb_tug_field;
  logic clk = 1'b0;
  logic rst, key_l, key_r, game_rst;
  logic [8:0] ledr;
  logic p1, p2, l, r;
  int n_cmp = 0;
  int n_err = 0;
  tug_field dut (
    .Clock(clk), .Reset(rst), .KeyL(key_l), .KeyR(key_r), .gameReset(game_rst),
    .LEDR(ledr), .P1LED9(p1), .P2LED1(p2), .L(l), .R(r)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic pl, input logic pr, output logic ol, output logic orr,
                       output logic o1, output logic o2);
    key_l = 1'b0;
    key_r = 1'b0;
    repeat (4) tick();
    key_l = pl;
    key_r = pr;
    repeat (3) tick();
    ol = l;
    orr = r;
    o1 = p1;
    o2 = p2;
    tick();
  endtask
  task automatic recentre();
    game_rst = 1'b1;
    tick();
    game_rst = 1'b0;
  endtask
  initial begin
    logic ol, orr, o1, o2;
    int cnt;
    rst = 1'b1;
    key_l = 1'b1;
    key_r = 1'b0;
    game_rst = 1'b0;
    repeat (3) tick();
    chk("rst_ledr", 32'(ledr), 32'h010);
    chk("rst_p1", 32'(p1), 0);
    chk("rst_p2", 32'(p2), 0);
    chk("rst_l", 32'(l), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(l);
    end
    chk("held_through_rst", cnt, 0);
    key_l = 1'b0;
    repeat (4) tick();
    key_l = 1'b1;
    repeat (2) tick();
    chk("lat_early", 32'(l), 0);
    tick();
    chk("lat_pulse", 32'(l), 1);
    chk("lat_no_r", 32'(r), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(l);
    end
    chk("hold_one_pulse", cnt, 0);
    chk("step_ledr", 32'(ledr), 32'h020);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, ol, orr, o1, o2);
    chk("max_p1", 32'(p1), 1);
    chk("max_ledr", 32'(ledr), 32'h100);
    press(1'b1, 1'b0, ol, orr, o1, o2);
    chk("sat_l", 32'(ol), 1);
    chk("sat_p1_with_l", 32'(o1), 1);
    chk("sat_ledr", 32'(ledr), 32'h100);
    recentre();
    chk("grst_centre", 32'(ledr), 32'h010);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, ol, orr, o1, o2);
    chk("min_p2", 32'(p2), 1);
    chk("min_ledr", 32'(ledr), 32'h001);
    press(1'b0, 1'b1, ol, orr, o1, o2);
    chk("sat_r", 32'(orr), 1);
    chk("sat_p2_with_r", 32'(o2), 1);
    chk("sat_min_ledr", 32'(ledr), 32'h001);
    press(1'b1, 1'b1, ol, orr, o1, o2);
    chk("both_l", 32'(ol), 1);
    chk("both_r", 32'(orr), 1);
    chk("both_ledr", 32'(ledr), 32'h001);
    recentre();
    press(1'b1, 1'b0, ol, orr, o1, o2);
    press(1'b1, 1'b0, ol, orr, o1, o2);
    chk("at7_ledr", 32'(ledr), 32'h040);
    key_l = 1'b0;
    repeat (4) tick();
    key_l = 1'b1;
    repeat (3) tick();
    chk("g7_l", 32'(l), 1);
    game_rst = 1'b1;
    tick();
    game_rst = 1'b0;
    chk("g7_ledr", 32'(ledr), 32'h010);
    chk("g7_l_low", 32'(l), 0);
    key_r = 1'b0;
    key_l = 1'b0;
    repeat (4) tick();
    key_r = 1'b1;
    repeat (2) tick();
    game_rst = 1'b1;
    tick();
    game_rst = 1'b0;
    chk("drop_r", 32'(r), 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(r);
    end
    chk("drop_no_refire", cnt, 0);
    chk("drop_ledr", 32'(ledr), 32'h010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
